mul_ctrl: RTL and testbench
===========================

# mul_ctrl

Sequencer and operand-preparation stage directly upstream of the radix-4 multi-cycle multiplier `mul`. It accepts RV32M multiply requests from the ALU issue path over a valid/ready handshake. It sign- or zero-extends both operands to 33 bits and drives the multiplier's `mul_sel_en`, `mul_start_en` and `pc_cycle` controls. It then selects the low or high word of the 66-bit product and returns it over a valid/ready response handshake.

## Interface
- `XLEN`, 32: architectural operand width; multiplier operand width is `XLEN+1` (`MULOP_LEN`).
- `CYC_W`, 5: width of `pc_cycle` (`MAX_DELAY_WIDTH`); must hold the value 18.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous abort of any in-flight operation.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_op`  in  2  operation select: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `req_rs1`, `req_rs2`  in  XLEN  source operands.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_data`  out  XLEN  result word; 0 when `resp_valid`=0.
- `busy`  out  1  high in START, ACC and DONE.
- `mul_op1`, `mul_op2`  out  XLEN+1  extended operands to `mul`.
- `mul_sel_en`  out  1  multiplier register load enable.
- `mul_start_en`  out  1  multiplier init strobe.
- `pc_cycle`  out  CYC_W  step index to `mul`.
- `mul_res`  in  2*(XLEN+1)  multiplier accumulator.

## Operation
- States: IDLE, START, ACC, DONE. The state, operand registers `op_q`/`rs1_q`/`rs2_q` and cycle counter are all registered.
- IDLE: when `req_valid` is high (and `req_ready` is therefore high), latch op and operands and go to START.
- Operand extension:
  - `mul_op1 = {s1 & rs1_q[31], rs1_q}`, where `s1` = op≠MULHU.
  - `mul_op2 = {s2 & rs2_q[31], rs2_q}`, where `s2` = op∈{MUL, MULH}.
  - Both are driven from registers and are stable for the whole operation.
- START (one cycle): `mul_sel_en`=1, `mul_start_en`=1, `pc_cycle`=1. Go to ACC.
- ACC (17 cycles, one per radix-4 digit of the 33-bit `op2`): `mul_sel_en`=1, `mul_start_en`=0, `pc_cycle`=2,3,…,18. Go to DONE after the cycle with `pc_cycle`=18.
- DONE: `mul_sel_en`=0, so `mul_res` is frozen. `resp_valid`=1.
  - `resp_data` = `mul_res[31:0]` for MUL, else `mul_res[63:32]`.
  - Hold until `resp_ready`, then go to IDLE.
- Outside START/ACC: `pc_cycle`=0, `mul_sel_en`=0, `mul_start_en`=0.
- `flush` has priority over every transition: next state is IDLE, no response is produced, and a pending DONE result is dropped. A `req_valid` arriving in the same cycle as `flush` is not accepted.
- `rst` forces the same state as `flush`. All outputs after reset: `req_ready`=1; every other output 0.
- Product bits 65:64 are ignored.

## Timing
- Accept edge T (IDLE with `req_valid`).
- START occupies cycle T+1. ACC occupies cycles T+2…T+18.
- `resp_valid` rises in cycle T+19 (19-cycle latency) and holds with `resp_data` stable until the `resp_ready` handshake.
- The earliest next accept is the cycle after the response handshake: `req_ready` rises the cycle after DONE exits.
- Back-to-back throughput is 1 operation per 20 cycles with `resp_ready` tied high.
- Combinational paths: `req_ready` and `busy` depend on state only; there is no combinational path from `req_valid` to `req_ready`.

## Configuration
- `MUL_ZERO_BYPASS_EN` defined:
  - An accepted request with `req_rs1`==0 or `req_rs2`==0 goes directly IDLE→DONE.
  - `mul_sel_en` stays 0 throughout.
  - `resp_data` is forced to 0.
  - `resp_valid` is asserted at T+1.
- `MUL_ZERO_BYPASS_EN` undefined: every request takes the full 19-cycle path.

## Test plan
- MUL, rs1=3, rs2=5, `resp_ready`=1 → `resp_valid` at T+19, `resp_data`=0x0000000F; `pc_cycle` sequence 1,2…18 observed on cycles T+1…T+18.
- MULH 0x80000000×0x80000000 → 0x40000000; MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- `resp_ready` held low for 5 cycles in DONE → `resp_valid` and `resp_data` stable; `req_ready` stays 0 until the cycle after the handshake.
- `flush` at `pc_cycle`=9, then MUL 7×6 issued → no response for the flushed op; next response is 0x0000002A; `rst` asserted mid-ACC gives the same result.
- With `MUL_ZERO_BYPASS_EN`: MULHU 0×0x1234 → `resp_valid` at T+1, `resp_data`=0, `mul_sel_en` never high. Without it: same request → response at T+19, value 0.

Source files
------------

// File: rtl/mul_ctrl_if.sv
// Request/response handshake bundle between the ALU issue path and mul_ctrl.
// The issuer uses the master modport; mul_ctrl uses the slave modport.
interface mul_ctrl_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;

    modport master (
        output req_valid, req_op, req_rs1, req_rs2, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/mul_ctrl.sv
// mul_ctrl: sequencer and operand preparation for the radix-4 multi-cycle
// multiplier. Accepts RV32M multiply requests, extends operands to 33 bits,
// steps the multiplier through 1 start + 17 accumulate cycles and returns
// the low or high product word.
// Optional feature macro: MUL_ZERO_BYPASS_EN (a zero operand skips straight
// to DONE with a forced zero result).
module mul_ctrl #(
    parameter int XLEN  = 32,
    parameter int CYC_W = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    mul_ctrl_if.slave               bus,
    output logic                    busy,
    output logic [XLEN:0]           mul_op1,
    output logic [XLEN:0]           mul_op2,
    output logic                    mul_sel_en,
    output logic                    mul_start_en,
    output logic [CYC_W-1:0]        pc_cycle,
    input  logic [2*(XLEN+1)-1:0]   mul_res
);
    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    localparam logic [CYC_W-1:0] CYC_START = CYC_W'(1);
    localparam logic [CYC_W-1:0] CYC_FIRST = CYC_W'(2);
    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(18);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        ACC   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [1:0]        op_reg, op_next;
    logic [XLEN-1:0]   rs1_reg, rs1_next;
    logic [XLEN-1:0]   rs2_reg, rs2_next;
    logic [CYC_W-1:0]  cyc_reg, cyc_next;
    logic              s1, s2;
    logic [XLEN-1:0]   prod_word;
    logic              unused_prod_top;

`ifdef MUL_ZERO_BYPASS_EN
    logic              zero_reg, zero_next;
`endif

    // State, operand and step-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            op_reg    <= 2'b00;
            rs1_reg   <= '0;
            rs2_reg   <= '0;
            cyc_reg   <= '0;
`ifdef MUL_ZERO_BYPASS_EN
            zero_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            rs1_reg   <= rs1_next;
            rs2_reg   <= rs2_next;
            cyc_reg   <= cyc_next;
`ifdef MUL_ZERO_BYPASS_EN
            zero_reg  <= zero_next;
`endif
        end
    end

    // Next-state logic; flush overrides every transition, including acceptance.
    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        rs1_next   = rs1_reg;
        rs2_next   = rs2_reg;
        cyc_next   = cyc_reg;
`ifdef MUL_ZERO_BYPASS_EN
        zero_next  = zero_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    op_next    = bus.req_op;
                    rs1_next   = bus.req_rs1;
                    rs2_next   = bus.req_rs2;
                    cyc_next   = CYC_START;
                    state_next = START;
`ifdef MUL_ZERO_BYPASS_EN
                    if (bus.req_rs1 == '0 || bus.req_rs2 == '0) begin
                        cyc_next   = '0;
                        zero_next  = 1'b1;
                        state_next = DONE;
                    end
`endif
                end
            end
            START: begin
                cyc_next   = CYC_FIRST;
                state_next = ACC;
            end
            ACC: begin
                if (cyc_reg == CYC_LAST) begin
                    cyc_next   = '0;
                    state_next = DONE;
                end else begin
                    cyc_next = cyc_reg + CYC_W'(1);
                end
            end
            DONE: begin
                if (bus.resp_ready) begin
                    state_next = IDLE;
`ifdef MUL_ZERO_BYPASS_EN
                    zero_next  = 1'b0;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
            cyc_next   = '0;
`ifdef MUL_ZERO_BYPASS_EN
            zero_next  = 1'b0;
`endif
        end
    end

    // Operand extension: op1 signed unless MULHU, op2 signed only for MUL/MULH.
    always_comb begin
        s1      = (op_reg != OP_MULHU);
        s2      = (op_reg == OP_MUL) || (op_reg == OP_MULH);
        mul_op1 = {s1 & rs1_reg[XLEN-1], rs1_reg};
        mul_op2 = {s2 & rs2_reg[XLEN-1], rs2_reg};
    end

    // Control strobes and response; all decoded from registered state only.
    always_comb begin
        bus.req_ready  = (state_reg == IDLE);
        busy           = (state_reg != IDLE);
        mul_sel_en     = (state_reg == START) || (state_reg == ACC);
        mul_start_en   = (state_reg == START);
        pc_cycle       = cyc_reg;
        bus.resp_valid = (state_reg == DONE);
        prod_word      = (op_reg == OP_MUL) ? mul_res[XLEN-1:0] : mul_res[2*XLEN-1:XLEN];
`ifdef MUL_ZERO_BYPASS_EN
        if (zero_reg) begin
            prod_word = '0;
        end
`endif
        bus.resp_data  = bus.resp_valid ? prod_word : '0;
    end

    // Top two product bits only matter for sign headroom inside the multiplier.
    assign unused_prod_top = ^mul_res[2*(XLEN+1)-1:2*XLEN];

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed testbench for mul_ctrl with a digit-serial radix-4 multiplier model
// standing in for `mul`. Expected results are hand-computed constants.
module tb_mul_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        busy;
    logic [32:0] mul_op1, mul_op2;
    logic        mul_sel_en, mul_start_en;
    logic [4:0]  pc_cycle;
    logic [65:0] mul_res;

    int n_checks = 0;
    int n_fail   = 0;

    mul_ctrl_if #(.XLEN(32)) bus ();

    mul_ctrl #(.XLEN(32), .CYC_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .bus          (bus),
        .busy         (busy),
        .mul_op1      (mul_op1),
        .mul_op2      (mul_op2),
        .mul_sel_en   (mul_sel_en),
        .mul_start_en (mul_start_en),
        .pc_cycle     (pc_cycle),
        .mul_res      (mul_res)
    );

    always #5 clk = ~clk;

    // Multiplier model: start clears, then pc_cycle k adds digit (k-2) of op2.
    logic [65:0] acc_reg;
    logic [65:0] partial;
    logic [65:0] a_ext;
    int          dig;
    always_comb begin
        a_ext   = {{33{mul_op1[32]}}, mul_op1};
        dig     = int'(pc_cycle) - 2;
        partial = '0;
        if (dig >= 0 && dig < 16)
            partial = (a_ext * {64'd0, mul_op2[2*dig+1], mul_op2[2*dig]}) << (2 * dig);
        else if (dig == 16 && mul_op2[32])
            partial = -(a_ext << 32);
    end
    always @(posedge clk) begin
        if (mul_sel_en) begin
            if (mul_start_en) acc_reg <= '0;
            else              acc_reg <= acc_reg + partial;
        end
    end
    assign mul_res = acc_reg;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, track latency/pc_cycle, optionally stall the response.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_data, input int exp_lat,
                          input logic exp_x1, input logic exp_x2, input int hold);
        int n;
        int pc_bad;
        int hold_bad;
        logic sel_seen;
        logic [31:0] first_data;
        @(negedge clk);
        check({tag, "_rdy_pre"}, bus.req_ready, 1'b1);
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_rs1    = a;
        bus.req_rs2    = b;
        bus.resp_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check({tag, "_ext"}, {mul_op1[32], mul_op2[32]}, {exp_x1, exp_x2});
        check({tag, "_busy"}, {busy, bus.req_ready}, 2'b10);
        n = 1;
        pc_bad = 0;
        sel_seen = 1'b0;
        forever begin
            if (mul_sel_en) sel_seen = 1'b1;
            if (exp_lat == 19 && n <= 18 && pc_cycle != 5'(n)) pc_bad++;
            if (bus.resp_valid || n >= 40) break;
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        check({tag, "_data"}, bus.resp_data, exp_data);
        if (exp_lat == 19) check({tag, "_pcseq"}, 64'(pc_bad), 64'd0);
        else               check({tag, "_nosel"}, sel_seen, 1'b0);
        if (hold > 0) begin
            hold_bad = 0;
            first_data = bus.resp_data;
            repeat (hold) begin
                @(posedge clk);
                #1;
                if (!bus.resp_valid || bus.resp_data != first_data || bus.req_ready) hold_bad++;
            end
            check({tag, "_hold"}, 64'(hold_bad), 64'd0);
            @(negedge clk);
            bus.resp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, "_after"}, {bus.req_ready, bus.resp_valid, busy}, 3'b100);
        bus.resp_ready = 1'b0;
    endtask

    // Start MUL 3x5, abort at pc_cycle 9 by flush or reset, then MUL 7x6.
    task automatic abort_run(input string tag, input logic use_rst);
        int n;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b00;
        bus.req_rs1   = 32'd3;
        bus.req_rs2   = 32'd5;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (pc_cycle != 5'd9 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_reach9"}, pc_cycle, 5'd9);
        @(negedge clk);
        if (use_rst) rst = 1'b1;
        else         flush = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        flush = 1'b0;
        check({tag, "_idle"}, {bus.req_ready, bus.resp_valid, busy, pc_cycle},
              {1'b1, 1'b0, 1'b0, 5'd0});
        run_op({tag, "_mul7x6"}, 2'b00, 32'd7, 32'd6, 32'h0000002A, 19, 1'b0, 1'b0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op = 2'b00;
        bus.req_rs1 = '0;
        bus.req_rs2 = '0;
        bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_outs", {bus.req_ready, bus.resp_valid, busy, mul_sel_en, mul_start_en, pc_cycle},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0});
        check("rst_data", bus.resp_data, 32'd0);
        check("rst_ops", {mul_op1, mul_op2}, 66'd0);

        run_op("mul_3x5",    2'b00, 32'd3,        32'd5,        32'h0000000F, 19, 1'b0, 1'b0, 0);
        run_op("mulh_min",   2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 19, 1'b1, 1'b1, 0);
        run_op("mulh_m1",    2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 19, 1'b1, 1'b1, 0);
        run_op("mulhu_max",  2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 19, 1'b0, 1'b0, 0);
        run_op("mulhsu_max", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 19, 1'b1, 1'b0, 0);
        run_op("stall",      2'b00, 32'd3,        32'd5,        32'h0000000F, 19, 1'b0, 1'b0, 5);

        // A request coinciding with flush must not be taken.
        @(negedge clk);
        bus.req_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        flush = 1'b0;
        check("flush_vs_req", {bus.req_ready, busy}, 2'b10);

        abort_run("flush", 1'b0);
        abort_run("reset", 1'b1);

`ifdef MUL_ZERO_BYPASS_EN
        run_op("zero_byp", 2'b11, 32'd0, 32'h00001234, 32'd0, 1, 1'b0, 1'b0, 0);
`else
        run_op("zero_full", 2'b11, 32'd0, 32'h00001234, 32'd0, 19, 1'b0, 1'b0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
